stm32_iq_streamer: RTL and testbench

- Parametrised successor to the fixed two-receiver RX IQ path of the STM32 parallel-bus interface.
- Buffers N-channel I/Q frames from the DDC chain in a synchronous FIFO. Serialises them byte-wise onto the 8-bit STM32 bus on request.
- Adds what the previous generation lacked: configurable channel count, sample width and depth, an optional status byte, and overflow/underflow accounting.
- Sits between the DDC outputs and the bus command decoder, which drives stream_start and byte_req.

---
 rtl/stm32_bus_pkg.sv | 39 +++
 rtl/iq_frame_fifo.sv | 63 ++++++
 rtl/stm32_iq_streamer.sv | 167 ++++++++++++++++
 tb/tb_stm32_iq_streamer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stm32_bus_pkg.sv
// Shared definitions for the STM32 parallel-bus blocks: streamer FSM states,
// bus command codes, status-byte layout and a constant-width helper.
package stm32_bus_pkg;

  // Streamer FSM. LOAD waits for the byte request that starts a new frame.
  // That same request emits the frame's first byte, which is the status byte
  // when one is configured. SEND shifts out the rest of the frame.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } stream_state_e;

  // Bus command codes decoded upstream by the command decoder
  localparam logic [7:0] CMD_NOP     = 8'd0;
  localparam logic [7:0] CMD_STATUS  = 8'd1;
  localparam logic [7:0] CMD_TX_IQ   = 8'd3;
  localparam logic [7:0] CMD_RX_IQ   = 8'd4;
  localparam logic [7:0] CMD_RX_STOP = 8'd5;

  // Status-byte bit positions
  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_UNF_BIT = 6;
  localparam int STAT_LVL_MSB = 5;

  // Ceiling log2, usable in port and parameter widths
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/iq_frame_fifo.sv
// Synchronous frame FIFO. A separate level counter keeps full and empty
// unambiguous. The read data is the word at the read pointer (first-word
// fall-through), so a pop can forward that word in the same cycle.
module iq_frame_fifo
  import stm32_bus_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [clog2(DEPTH):0] level,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot that a push into a full FIFO needs
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // Storage write
  // NOTE: the array has no reset. Resetting the pointers and the level makes
  // stale words unreachable, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/stm32_iq_streamer.sv
// Buffers N-channel I/Q frames and serialises them byte-wise onto the 8-bit
// STM32 bus. A frame is an optional status byte, followed by Q then I of each
// enabled channel in ascending channel order, each sample MSB-first.
module stm32_iq_streamer
  import stm32_bus_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int STATUS_BYTE  = 1
) (
  input  logic                             clk_in,
  input  logic                             reset,
  input  logic                             iq_valid,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] rx_i,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] rx_q,
  input  logic [CHANNELS-1:0]              chan_mask,
  input  logic                             stream_start,
  input  logic                             stream_stop,
  input  logic                             byte_req,
  output logic [7:0]                       data_out,
  output logic                             data_valid,
  output logic                             data_oe,
  output logic [clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                             overflow,
  output logic [15:0]                      underflow_cnt
);

  localparam int SW      = SAMPLE_WIDTH;
  localparam int FRAME_W = CHANNELS * 2 * SW;
  localparam int BPS     = SW / 8;
  localparam int MAX_LEN = STATUS_BYTE + CHANNELS * 2 * BPS;
  localparam int CNT_W   = clog2(MAX_LEN + 1);
  localparam int LVL_W   = clog2(FIFO_DEPTH) + 1;

  stream_state_e      state;
  logic [FRAME_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               load_fire;
  logic               send_fire;
  logic               pop;
  logic               drop;
  logic [FRAME_W-1:0] src_frame;
  logic [FRAME_W-1:0] packed_payload;
  logic [FRAME_W-1:0] payload;
  logic [CNT_W-1:0]   frame_len;
  logic [CNT_W-1:0]   bytes_left;
  logic [LVL_W-1:0]   level_after;
  logic [6:0]         level_ext;
  logic [7:0]         status_byte;
  int                 slot;

  // Each FIFO word is {all Q samples, all I samples}, channel 0 in the LSBs
  iq_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .push    (iq_valid),
    .pop     (pop),
    .wr_data ({rx_q, rx_i}),
    .rd_data (fifo_rd),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Request decode. Start and stop take the cycle, so a byte request
  // arriving with either of them is not served.
  always_comb begin
    load_fire = (state == ST_LOAD) && byte_req && !stream_start && !stream_stop;
    send_fire = (state == ST_SEND) && byte_req && !stream_start && !stream_stop;
    pop       = load_fire && !fifo_empty;
    drop      = iq_valid && fifo_full && !pop;
  end

  // Compact the enabled channels into a left-aligned byte stream and size it
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    src_frame      = fifo_empty ? '0 : fifo_rd;
    packed_payload = '0;
    slot           = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_mask[c]) begin
        packed_payload[FRAME_W-1-slot*2*SW -: 2*SW] =
          {src_frame[CHANNELS*SW + c*SW +: SW], src_frame[c*SW +: SW]};
        slot++;
      end
    end
    frame_len = CNT_W'(STATUS_BYTE) + CNT_W'(slot * 2 * BPS);
    // An empty mask without a status byte still sends one 0x00 byte
    if (frame_len == '0) frame_len = CNT_W'(1);
  end

  // Status byte: sticky overflow, underflow of this frame, level after the pop
  always_comb begin
    level_after = fifo_level - LVL_W'(pop);
    level_ext   = 7'(level_after);
    status_byte = '0;
    status_byte[STAT_OVF_BIT] = overflow;
    status_byte[STAT_UNF_BIT] = fifo_empty;
    status_byte[STAT_LVL_MSB:0] = (level_ext > 7'd63) ? 6'd63 : level_ext[5:0];
  end

  // Stream FSM, serialiser and accounting, all outputs registered
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      data_out      <= '0;
      data_valid    <= 1'b0;
      data_oe       <= 1'b0;
      payload       <= '0;
      bytes_left    <= '0;
      overflow      <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      data_valid <= 1'b0;

      if (stream_start)  overflow <= 1'b0;
      else if (drop)     overflow <= 1'b1;

      if (stream_start) begin
        state   <= ST_LOAD;
        data_oe <= 1'b1;
      end else if (stream_stop) begin
        state   <= ST_IDLE;
        data_oe <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (load_fire) begin
              data_valid <= 1'b1;
              if (fifo_empty && (underflow_cnt != 16'hFFFF))
                underflow_cnt <= underflow_cnt + 16'd1;
              if (STATUS_BYTE != 0) begin
                data_out <= status_byte;
                payload  <= packed_payload;
              end else begin
                data_out <= packed_payload[FRAME_W-1 -: 8];
                payload  <= {packed_payload[FRAME_W-9:0], 8'h00};
              end
              // Frame-end decision: single-byte frames stay in LOAD
              if (frame_len > CNT_W'(1)) begin
                state      <= ST_SEND;
                bytes_left <= frame_len - CNT_W'(1);
              end
            end
          end
          ST_SEND: begin
            if (send_fire) begin
              data_valid <= 1'b1;
              data_out   <= payload[FRAME_W-1 -: 8];
              payload    <= {payload[FRAME_W-9:0], 8'h00};
              bytes_left <= bytes_left - CNT_W'(1);
              if (bytes_left == CNT_W'(1)) state <= ST_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stm32_iq_streamer.sv
// Scoreboard bench for stm32_iq_streamer. dut_a uses the default
// configuration and is checked against a frame-level reference model.
// dut_b (4 channels, 16-bit samples, no status byte) covers mask selection
// and mask changes in the middle of a frame.
module tb_stm32_iq_streamer;

  typedef struct packed {
    logic [63:0] i;
    logic [63:0] q;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_iq_valid = 1'b0;
  logic [63:0] a_rx_i = '0, a_rx_q = '0;
  logic [1:0]  a_mask = '0;
  logic        a_start = 1'b0, a_stop = 1'b0, a_req = 1'b0;
  logic [7:0]  a_data;
  logic        a_valid, a_oe, a_ovf;
  logic [3:0]  a_level;
  logic [15:0] a_ucnt;

  logic        b_iq_valid = 1'b0;
  logic [63:0] b_rx_i = '0, b_rx_q = '0;
  logic [3:0]  b_mask = '0;
  logic        b_start = 1'b0, b_stop = 1'b0, b_req = 1'b0;
  logic [7:0]  b_data;
  logic        b_valid, b_oe, b_ovf;
  logic [2:0]  b_level;
  logic [15:0] b_ucnt;

  stm32_iq_streamer #(.CHANNELS(2), .SAMPLE_WIDTH(32), .FIFO_DEPTH(8), .STATUS_BYTE(1)) dut_a (
    .clk_in(clk), .reset(rst), .iq_valid(a_iq_valid), .rx_i(a_rx_i), .rx_q(a_rx_q),
    .chan_mask(a_mask), .stream_start(a_start), .stream_stop(a_stop), .byte_req(a_req),
    .data_out(a_data), .data_valid(a_valid), .data_oe(a_oe), .fifo_level(a_level),
    .overflow(a_ovf), .underflow_cnt(a_ucnt));

  stm32_iq_streamer #(.CHANNELS(4), .SAMPLE_WIDTH(16), .FIFO_DEPTH(4), .STATUS_BYTE(0)) dut_b (
    .clk_in(clk), .reset(rst), .iq_valid(b_iq_valid), .rx_i(b_rx_i), .rx_q(b_rx_q),
    .chan_mask(b_mask), .stream_start(b_start), .stream_stop(b_stop), .byte_req(b_req),
    .data_out(b_data), .data_valid(b_valid), .data_oe(b_oe), .fifo_level(b_level),
    .overflow(b_ovf), .underflow_cnt(b_ucnt));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state for dut_a
  frame_t     mq[$];
  logic [7:0] pend[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] fb[$];
  bit         m_ovf = 0;
  bit         m_stream = 0;
  int         m_ucnt = 0;

  // Byte sequence of one frame, built directly from the frame format rules
  task automatic build_frame(input int ch, input int sw, input bit stat, input logic [3:0] mask,
                             input frame_t f, input logic [7:0] status);
    logic [63:0] s;
    fb.delete();
    if (stat) fb.push_back(status);
    for (int c = 0; c < ch; c++) begin
      if (mask[c]) begin
        s = f.q >> (c * sw);
        for (int b = sw / 8 - 1; b >= 0; b--) fb.push_back(s[b*8 +: 8]);
        s = f.i >> (c * sw);
        for (int b = sw / 8 - 1; b >= 0; b--) fb.push_back(s[b*8 +: 8]);
      end
    end
    if (fb.size() == 0) fb.push_back(8'h00);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    f.i = {$urandom, $urandom};
    f.q = {$urandom, $urandom};
    return f;
  endfunction

  // One clock of dut_a stimulus; the model predicts what that edge does
  task automatic step_a(input bit v, input frame_t f, input logic [1:0] mask,
                        input bit start, input bit stop, input bit req);
    frame_t     pf;
    int         lvl;
    logic [7:0] st;
    a_iq_valid = v; a_rx_i = f.i; a_rx_q = f.q; a_mask = mask;
    a_start = start; a_stop = stop; a_req = req;
    if (start) begin
      m_stream = 1; pend.delete();
    end else if (stop) begin
      m_stream = 0; pend.delete();
    end else if (req && m_stream) begin
      if (pend.size() == 0) begin
        pf = '0;
        if (mq.size() > 0) pf = mq.pop_front();
        else if (m_ucnt < 65535) m_ucnt++;
        lvl = mq.size();
        if (lvl > 63) lvl = 63;
        st = {m_ovf, (pf == '0) && (m_ucnt > 0) && (st_underflow(pf)), 6'(lvl)};
        build_frame(2, 32, 1, {2'b00, mask}, pf, st);
        pend = fb;
      end
      exp_a.push_back(pend.pop_front());
    end
    if (v) begin
      if (mq.size() < 8) mq.push_back(f);
      else m_ovf = 1;
    end
    if (start) m_ovf = 0;
    @(posedge clk);
    #1;
  endtask

  // Tracks whether the model's most recent load found the queue empty
  bit last_load_empty = 0;
  function automatic bit st_underflow(input frame_t pf);
    return last_load_empty;
  endfunction

  task automatic req_a(input logic [1:0] mask);
    last_load_empty = (pend.size() == 0) && (mq.size() == 0);
    step_a(0, '0, mask, 0, 0, 1);
  endtask

  task automatic idle_a(input int n);
    repeat (n) step_a(0, '0, 2'b11, 0, 0, 0);
  endtask

  task automatic step_b(input bit v, input frame_t f, input logic [3:0] mask,
                        input bit start, input bit stop, input bit req);
    b_iq_valid = v; b_rx_i = f.i; b_rx_q = f.q; b_mask = mask;
    b_start = start; b_stop = stop; b_req = req;
    @(posedge clk);
    #1;
  endtask

  task automatic model_checks(input string tag);
    check({tag, "_level"}, 32'(a_level), mq.size());
    check({tag, "_overflow"}, 32'(a_ovf), 32'(m_ovf));
    check({tag, "_ucnt"}, 32'(a_ucnt), m_ucnt);
    check({tag, "_oe"}, 32'(a_oe), 32'(m_stream));
  endtask

  // Monitors: pop the scoreboard whenever a DUT presents a byte
  always @(negedge clk) begin
    if (!rst && a_valid) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_byte: got unexpected byte 0x%0h expected none", a_data);
      end else check("a_byte", 32'(a_data), 32'(exp_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && b_valid) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_byte: got unexpected byte 0x%0h expected none", b_data);
      end else check("b_byte", 32'(b_data), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    frame_t f, f1, f2;
    bit start, stop, req, v;
    int r;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(a_data), 0);
    check("rst_data_valid", 32'(a_valid), 0);
    check("rst_data_oe", 32'(a_oe), 0);
    check("rst_level", 32'(a_level), 0);
    check("rst_overflow", 32'(a_ovf), 0);
    check("rst_ucnt", 32'(a_ucnt), 0);
    rst = 1'b0;
    idle_a(2);

    // Known frame, both channels, with status byte
    f.i = {32'hAABBCCDD, 32'h11223344};
    f.q = {32'h01020304, 32'h55667788};
    step_a(1, f, 2'b11, 0, 0, 0);
    check("t1_level_after_push", 32'(a_level), 1);
    step_a(0, '0, 2'b11, 1, 0, 0);
    check("t1_oe_after_start", 32'(a_oe), 1);
    repeat (17) req_a(2'b11);
    idle_a(1);
    model_checks("t1");

    // Underflow frame, channel 0 only
    step_a(0, '0, 2'b01, 0, 1, 0);
    step_a(0, '0, 2'b01, 1, 0, 0);
    repeat (9) req_a(2'b01);
    idle_a(1);
    check("t2_ucnt", 32'(a_ucnt), 1);
    model_checks("t2");

    // Overflow: nine frames into a depth-8 FIFO, then drain in order
    step_a(0, '0, 2'b11, 0, 1, 0);
    step_a(0, '0, 2'b11, 1, 0, 0);
    repeat (9) step_a(1, rand_frame(), 2'b11, 0, 0, 0);
    check("t3_level_full", 32'(a_level), 8);
    check("t3_overflow", 32'(a_ovf), 1);
    repeat (8 * 17) req_a(2'b11);
    idle_a(1);
    model_checks("t3");

    // Full FIFO with push and pop on the same load cycle
    step_a(0, '0, 2'b11, 0, 1, 0);
    step_a(0, '0, 2'b11, 1, 0, 0);
    repeat (8) step_a(1, rand_frame(), 2'b11, 0, 0, 0);
    last_load_empty = 0;
    step_a(1, rand_frame(), 2'b11, 0, 0, 1);
    check("t4_level_held", 32'(a_level), 8);
    check("t4_overflow_clear", 32'(a_ovf), 0);
    repeat (16) req_a(2'b11);
    idle_a(1);
    model_checks("t4");

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      r     = $urandom_range(0, 99);
      start = (r < 2);
      stop  = (r >= 2) && (r < 4);
      req   = !start && !stop && ($urandom_range(0, 1) == 1);
      v     = !start && ($urandom_range(0, 2) == 0);
      last_load_empty = (pend.size() == 0) && (mq.size() == 0);
      step_a(v, rand_frame(), 2'($urandom_range(0, 3)), start, stop, req);
      model_checks("rnd");
    end
    step_a(0, '0, 2'b11, 0, 1, 0);
    idle_a(1);

    // dut_b: mask 1010, mask change mid-frame applies to the next frame
    f1 = rand_frame();
    f2 = rand_frame();
    step_b(1, f1, 4'b1010, 0, 0, 0);
    step_b(1, f2, 4'b1010, 0, 0, 0);
    step_b(0, '0, 4'b1010, 1, 0, 0);
    check("b_level_two", 32'(b_level), 2);
    check("b_oe", 32'(b_oe), 1);
    build_frame(4, 16, 0, 4'b1010, f1, 8'h00);
    foreach (fb[k]) exp_b.push_back(fb[k]);
    repeat (3) step_b(0, '0, 4'b1010, 0, 0, 1);
    repeat (5) step_b(0, '0, 4'b0101, 0, 0, 1);
    build_frame(4, 16, 0, 4'b0101, f2, 8'h00);
    foreach (fb[k]) exp_b.push_back(fb[k]);
    repeat (8) step_b(0, '0, 4'b0101, 0, 0, 1);
    step_b(0, '0, 4'b0101, 0, 0, 0);
    check("b_level_empty", 32'(b_level), 0);
    check("b_ucnt", 32'(b_ucnt), 0);
    step_b(0, '0, 4'b0101, 0, 1, 0);
    step_b(0, '0, 4'b0101, 0, 0, 0);
    check("b_oe_after_stop", 32'(b_oe), 0);

    // Reset in the middle of a frame
    step_a(0, '0, 2'b11, 1, 0, 0);
    repeat (9) step_a(1, rand_frame(), 2'b11, 0, 0, 0);
    repeat (5) req_a(2'b11);
    idle_a(1);
    rst = 1'b1;
    #1;
    check("mr_oe", 32'(a_oe), 0);
    check("mr_level", 32'(a_level), 0);
    check("mr_overflow", 32'(a_ovf), 0);
    check("mr_valid", 32'(a_valid), 0);
    mq.delete(); pend.delete();
    m_ovf = 0; m_ucnt = 0; m_stream = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step_a(0, '0, 2'b11, 1, 0, 0);
    repeat (17) req_a(2'b11);
    idle_a(2);
    check("mr_ucnt", 32'(a_ucnt), 1);
    model_checks("mr");

    check("a_scoreboard_drained", exp_a.size(), 0);
    check("b_scoreboard_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
